// File: rtl/alu74181_pkg.sv
// Shared types and function encodings for the 74181-based ALU scheduler.
package alu74181_pkg;

   // Common logic-mode functions (active-high data); all use m = 1.
   localparam logic [3:0] F_XOR  = 4'b0110;
   localparam logic [3:0] F_AND  = 4'b1011;
   localparam logic [3:0] F_OR   = 4'b1110;
   localparam logic [3:0] F_NOTA = 4'b0000;

   localparam logic M_LOGIC = 1'b1;
   localparam logic M_ARITH = 1'b0;

   // One complete ALU command as presented by a requester.
   typedef struct packed {
      logic [3:0] s;
      logic       m;
      logic       ci;
      logic [3:0] a;
      logic [3:0] b;
   } alu_cmd_t;

endpackage

// File: rtl/alu74181.sv
// 4-bit 74181-style ALU, active-high data, ci = 1 adds one in arithmetic mode.
module alu74181 (
   input  logic [3:0] s,
   input  logic       m,
   input  logic       ci,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);

   logic [3:0] x_term;
   logic [3:0] y_term;
   logic [3:0] sum;

   // Per-bit propagate/generate terms; y_term is always a subset of x_term,
   // so the logic result reduces to an XNOR and the arithmetic one to a sum.
   always_comb begin
      x_term = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
      y_term = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
      sum    = x_term + y_term + {3'b000, ci};
      y      = m ? ~(x_term ^ y_term) : sum;
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr, ptr moves past each winner.
module alu_rr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic [IDW-1:0]  ptr
);

   logic [IDW-1:0] cand;
   logic           found;

   // First requester at or after ptr (modulo NREQ) wins when enabled.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr) + k) % NREQ);
         if (enable && !found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Pointer moves to the slot after the accepted requester; holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/alu74181_rr_sched.sv
// Shares one alu74181 among NREQ requesters through an issue/result pipeline.
module alu74181_rr_sched
   import alu74181_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_s,
   input  logic [NREQ-1:0]   req_m,
   input  logic [NREQ-1:0]   req_ci,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [3:0]        resp_y,
   output logic [IDW-1:0]    resp_id,
   output logic              busy
);

   logic           s1_valid;
   alu_cmd_t       s1_cmd;
   logic [IDW-1:0] s1_id;
   logic           s2_valid;
   logic [3:0]     s2_y;
   logic [IDW-1:0] s2_id;

   logic           s2_load;
   logic           s1_free;
   logic           accept;
   alu_cmd_t       sel_cmd;
   logic [3:0]     alu_y;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] rr_ptr;
   logic           unused_ptr;

   assign s2_load = s1_valid && (!s2_valid || resp_ready);
   assign s1_free = !s1_valid || s2_load;
   assign accept  = |grant;

   // rr_ptr is kept as a named net so it can be observed from outside.
   assign unused_ptr = ^rr_ptr;

   // Grants are suppressed while reset is asserted so req_ready drops at once.
   alu_rr_arbiter #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req_valid),
      .enable   (s1_free && reset_n),
      .advance  (accept),
      .grant    (grant),
      .grant_idx(grant_idx),
      .ptr      (rr_ptr)
   );

   assign req_ready = grant;

   // Select the granted requester's command fields.
   always_comb begin
      sel_cmd = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_cmd = '{s: req_s[4*i +: 4], m: req_m[i], ci: req_ci[i],
                        a: req_a[4*i +: 4], b: req_b[4*i +: 4]};
         end
      end
   end

   // Issue register: refill on accept, empty when it drains without a refill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_cmd   <= '0;
         s1_id    <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_cmd   <= sel_cmd;
         s1_id    <= grant_idx;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   alu74181 u_alu (
      .s (s1_cmd.s),
      .m (s1_cmd.m),
      .ci(s1_cmd.ci),
      .a (s1_cmd.a),
      .b (s1_cmd.b),
      .y (alu_y)
   );

   // Result register: loads from the ALU, empties on a response with no reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_y     <= '0;
         s2_id    <= '0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         s2_y     <= alu_y;
         s2_id    <= s1_id;
      end else if (resp_valid && resp_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign resp_valid = s2_valid;
   assign resp_y     = s2_y;
   assign resp_id    = s2_id;
   assign busy       = s1_valid | s2_valid;

endmodule

// File: doc/alu74181_rr_sched.md
Name: alu74181_rr_sched

Overview:
Round-robin scheduler that shares one alu74181 instance between NREQ requesters. Each requester presents a complete ALU command (s, M, ci, a, b) with a valid/ready handshake. Granted commands go through a two-stage pipeline: an issue register drives the ALU, and a result register holds y tagged with the requester id. Results return on a single response channel with backpressure.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, $clog2(NREQ) (min 1), width of requester id tag

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_s  in  4*NREQ  ALU function select, slice i = [4i+3:4i]
req_m  in  NREQ  ALU mode (1 = logic, 0 = arithmetic)
req_ci  in  NREQ  ALU carry-in
req_a  in  4*NREQ  operand A, slice i
req_b  in  4*NREQ  operand B, slice i
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_y  out  4  ALU result
resp_id  out  IDW  index of the requester that issued the command
busy  out  1  either pipeline stage occupied

Behaviour:
- Stage 1 (issue register): s1_valid, s, m, ci, a, b, id. Drives the alu74181 instance combinationally.
- Stage 2 (result register): s2_valid, y, id. Drives the resp_* outputs directly.
- s2_load = s1_valid && (!s2_valid || resp_ready).
- s1_free = !s1_valid || s2_load.
- Arbitration:
  - Combinational. When s1_free, grant the first i with req_valid[i] set, searching from ptr upward modulo NREQ.
  - req_ready[grant] = 1; every other req_ready bit = 0.
  - When !s1_free, or no requester is valid, req_ready = 0.
- On acceptance (req_valid[i] && req_ready[i]):
  - Stage 1 captures requester i's fields and id = i; s1_valid = 1.
  - ptr <= (i+1) mod NREQ.
  - ptr does not move when nothing is accepted.
- Stage 1 drain without refill: when s2_load happens and nothing is accepted, s1_valid <= 0.
- On s2_load: s2 captures the ALU y and s1.id; s2_valid = 1.
- On resp_valid && resp_ready with no s2_load: s2_valid <= 0.
- resp_valid = s2_valid. resp_y and resp_id stay stable while resp_valid && !resp_ready.
- Latency: a command accepted at edge N appears on resp_* after edge N+1, i.e. two cycles from request to response.
- Throughput: one command per cycle while resp_ready = 1.
- Requester obligation: hold all fields stable while valid && !ready. Fields are don't-care while valid is low.
- Reset (reset_n low, asynchronous):
  - s1_valid = s2_valid = 0, ptr = 0, resp_y = 0, resp_id = 0.
  - All stage-1 data is cleared to 0.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - Any in-flight commands are discarded, not replayed.
- Boundary conditions:
  - All requesters valid continuously with resp_ready = 1: grants cycle 0, 1, ..., NREQ-1, 0, ... with no starvation.
  - Both stages full and resp_ready = 0: req_ready = 0, and the state holds indefinitely.
  - Full pipeline and resp_ready = 1 in the same cycle: the response drains, stage 1 moves to stage 2, and a new command is accepted, all in that one edge.
  - Single requester valid: it is granted every free cycle regardless of ptr.
- busy = s1_valid | s2_valid.

Decomposition:
- Package alu74181_pkg:
  - S/M encodings: F_XOR = 0110/M1, F_AND = 1011/M1, F_OR = 1110/M1, F_NOTA = 0000/M1.
  - The command struct {s, m, ci, a, b}.
- Sub-module alu_rr_arbiter (NREQ): req vector, enable and advance in; one-hot grant, grant index and ptr register out.
- The existing alu74181 is instantiated unchanged.

Test Plan:
- Single op: req0 s=0110 m=1 a=1010 b=0110, resp_ready=1 -> resp_valid two cycles after acceptance, y=1100, id=0.
- Fairness, NREQ=2: both valid continuously with AND, a0=1111 b0=0101 and a1=0011 b1=1110 -> responses alternate id 0,1,0,1 with y=0101 and y=0010.
- Backpressure: issue 3 back-to-back ORs from req1, hold resp_ready=0 -> two accepted, then req_ready=0. Release -> y values in order, none lost or duplicated.
- Full-pipe simultaneity: pipe full, resp_ready=1, req0 valid -> drain, shift and accept in one edge; resp_valid stays 1 continuously.
- Reset mid-operation: both stages full, pulse reset_n low asynchronously -> resp_valid, busy and req_ready drop immediately. After release ptr=0, so with both valid the first grant goes to id 0.
- Idle: no req_valid for 10 cycles -> req_ready=0, busy=0, resp_valid=0, ptr unchanged.
